// File: rtl/audio_controller_n.sv
// audio_controller_n: N-channel audio controller core.
// CPU register file, round-robin DMA arbiter, per-channel volume, saturating
// stereo mixer and masked busy-falling-edge interrupt.
module audio_controller_n #(
  parameter int          CHANNELS     = 8,
  parameter int          SAMPLE_W     = 16,
  parameter int          VOL_W        = 8,
  parameter logic [31:0] DEFAULT_RATE = 32'd17
) (
  input  logic                                i_clock,
  input  logic                                i_reset_n,
  input  logic                                i_request,
  input  logic                                i_rw,
  input  logic [7:0]                          i_address,
  input  logic [31:0]                         i_wdata,
  output logic [31:0]                         o_rdata,
  output logic                                o_ready,
  output logic                                o_dma_request,
  output logic [31:0]                         o_dma_address,
  input  logic                                i_dma_ready,
  output logic [CHANNELS-1:0]                 o_setup_request,
  output logic [CHANNELS*32-1:0]              o_setup_address,
  output logic [CHANNELS*24-1:0]              o_setup_count,
  output logic [CHANNELS-1:0]                 o_setup_append,
  output logic [CHANNELS-1:0]                 o_setup_stereo,
  input  logic [CHANNELS-1:0]                 i_ch_busy,
  input  logic [CHANNELS-1:0]                 i_ch_dma_request,
  input  logic [CHANNELS*32-1:0]              i_ch_dma_address,
  output logic [CHANNELS-1:0]                 o_ch_dma_ready,
  input  logic [CHANNELS*SAMPLE_W-1:0]        i_ch_sample_left,
  input  logic [CHANNELS*SAMPLE_W-1:0]        i_ch_sample_right,
  input  logic                                i_sample_strobe,
  output logic [31:0]                         o_output_sample_rate,
  output logic signed [SAMPLE_W-1:0]          o_output_sample_left,
  output logic signed [SAMPLE_W-1:0]          o_output_sample_right,
  output logic                                o_interrupt
);

  localparam int IW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PROD_W = SAMPLE_W + VOL_W + 1;
  localparam int ACC_W  = SAMPLE_W + VOL_W + $clog2(CHANNELS) + 1;

  localparam logic [VOL_W-1:0] VOL_UNITY = {1'b1, {(VOL_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (SAMPLE_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 << (SAMPLE_W-1)));

  typedef enum logic { ARB_IDLE, ARB_GRANT } arb_state_t;
  typedef enum logic [1:0] { MIX_IDLE, MIX_ACC, MIX_OUT } mix_state_t;

  // Scale one sample by an unsigned volume; unity volume is a pass-through.
  function automatic logic signed [ACC_W-1:0] scale_sample(
    input logic signed [SAMPLE_W-1:0] s,
    input logic        [VOL_W-1:0]    v
  );
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(s) * PROD_W'($signed({1'b0, v}));
    return ACC_W'(p >>> (VOL_W-1));
  endfunction

  // Clip the wide accumulator into the signed output sample range.
  function automatic logic signed [SAMPLE_W-1:0] saturate(
    input logic signed [ACC_W-1:0] a
  );
    if (a > SAT_MAX)      return SAT_MAX[SAMPLE_W-1:0];
    else if (a < SAT_MIN) return SAT_MIN[SAMPLE_W-1:0];
    else                  return a[SAMPLE_W-1:0];
  endfunction

  logic [CHANNELS*VOL_W-1:0] vol;
  logic [CHANNELS-1:0]       irq_mask;
  logic [CHANNELS-1:0]       pending;
  logic [CHANNELS-1:0]       busy_r;

  logic                      access;
  logic                      in_ch;
  logic [IW-1:0]             ch;
  logic [1:0]                reg_sel;
  logic [31:0]               rd_val;
  logic [CHANNELS-1:0]       clr;

  arb_state_t                arb_state;
  logic [IW-1:0]             ptr;
  logic [IW-1:0]             grant;
  logic [IW-1:0]             pick;
  logic                      pick_valid;

  mix_state_t                mix_state;
  logic [IW-1:0]             mix_idx;
  logic signed [ACC_W-1:0]   acc_l;
  logic signed [ACC_W-1:0]   acc_r;

  // Bits 31:30 and 27:24 of a ctrl write carry no meaning.
  logic unused_wdata;
  assign unused_wdata = ^i_wdata;

  // CPU address decode and read-data mux.
  always_comb begin
    access  = i_request && !o_ready;
    in_ch   = int'(i_address) < 4 * CHANNELS;
    ch      = IW'(i_address[7:2]);
    reg_sel = i_address[1:0];
    rd_val  = '0;
    clr     = '0;
    if (in_ch) begin
      case (reg_sel)
        2'd0:    rd_val = o_setup_address[ch*32 +: 32];
        2'd1:    rd_val = {2'b00, o_setup_stereo[ch], o_setup_append[ch], 4'b0000,
                           o_setup_count[ch*24 +: 24]};
        2'd2:    rd_val = 32'(vol[ch*VOL_W +: VOL_W]);
        default: rd_val = '0;
      endcase
    end else begin
      case (i_address)
        8'hF0:   rd_val = o_output_sample_rate;
        8'hF1:   rd_val = 32'(i_ch_busy);
        8'hF2:   rd_val = 32'(pending);
        8'hF3:   rd_val = 32'(irq_mask);
        default: rd_val = '0;
      endcase
    end
    if (access && i_rw && i_address == 8'hF2) clr = i_wdata[CHANNELS-1:0];
  end

  // CPU register file: single-cycle handshake, writes, read capture, setup pulses.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      o_ready              <= 1'b0;
      o_rdata              <= '0;
      o_setup_request      <= '0;
      o_setup_address      <= '0;
      o_setup_count        <= '0;
      o_setup_append       <= '0;
      o_setup_stereo       <= '0;
      vol                  <= {CHANNELS{VOL_UNITY}};
      o_output_sample_rate <= DEFAULT_RATE;
      irq_mask             <= '1;
    end else begin
      o_setup_request <= '0;
      if (access) begin
        o_ready <= 1'b1;
        if (i_rw) begin
          if (in_ch) begin
            case (reg_sel)
              2'd0: o_setup_address[ch*32 +: 32] <= i_wdata;
              2'd1: begin
                o_setup_count[ch*24 +: 24] <= i_wdata[23:0];
                o_setup_append[ch]         <= i_wdata[28];
                o_setup_stereo[ch]         <= i_wdata[29];
                o_setup_request[ch]        <= 1'b1;
              end
              2'd2:    vol[ch*VOL_W +: VOL_W] <= i_wdata[VOL_W-1:0];
              default: ;
            endcase
          end else begin
            case (i_address)
              8'hF0:   o_output_sample_rate <= i_wdata;
              8'hF3:   irq_mask             <= i_wdata[CHANNELS-1:0];
              default: ;
            endcase
          end
        end else begin
          o_rdata <= rd_val;
        end
      end else if (!i_request) begin
        o_ready <= 1'b0;
      end
    end
  end

  // Busy falling-edge detection, sticky pending bits (set beats clear), masked irq.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      busy_r      <= '0;
      pending     <= '0;
      o_interrupt <= 1'b0;
    end else begin
      busy_r      <= i_ch_busy;
      pending     <= (pending & ~clr) | (busy_r & ~i_ch_busy);
      o_interrupt <= |(pending & irq_mask);
    end
  end

  // Round-robin search: first requester at or after the pointer, with wrap.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (i_ch_dma_request[j]) begin
        pick_valid = 1'b1;
        pick       = IW'(j);
      end
    end
  end

  // Route the DMA completion only to the granted channel.
  always_comb begin
    o_ch_dma_ready = '0;
    if (arb_state == ARB_GRANT) o_ch_dma_ready[grant] = i_dma_ready;
  end

  // DMA arbiter FSM: a grant runs until acknowledged, then the pointer moves past it.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      arb_state     <= ARB_IDLE;
      ptr           <= '0;
      grant         <= '0;
      o_dma_request <= 1'b0;
      o_dma_address <= '0;
    end else begin
      case (arb_state)
        ARB_IDLE: begin
          if (pick_valid) begin
            grant         <= pick;
            o_dma_request <= 1'b1;
            o_dma_address <= i_ch_dma_address[pick*32 +: 32];
            arb_state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (i_dma_ready) begin
            o_dma_request <= 1'b0;
            ptr           <= (grant == IW'(CHANNELS-1)) ? '0 : grant + 1'b1;
            arb_state     <= ARB_IDLE;
          end
        end
        default: arb_state <= ARB_IDLE;
      endcase
    end
  end

  // Mixer FSM: accumulate one channel per cycle at full width, clip once at the end.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      mix_state             <= MIX_IDLE;
      mix_idx               <= '0;
      o_output_sample_left  <= '0;
      o_output_sample_right <= '0;
    end else begin
      case (mix_state)
        MIX_IDLE: begin
          if (i_sample_strobe) begin
            mix_idx   <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            mix_state <= MIX_ACC;
          end
        end
        MIX_ACC: begin
          acc_l <= acc_l + scale_sample(i_ch_sample_left[mix_idx*SAMPLE_W +: SAMPLE_W],
                                        vol[mix_idx*VOL_W +: VOL_W]);
          acc_r <= acc_r + scale_sample(i_ch_sample_right[mix_idx*SAMPLE_W +: SAMPLE_W],
                                        vol[mix_idx*VOL_W +: VOL_W]);
          if (mix_idx == IW'(CHANNELS-1)) mix_state <= MIX_OUT;
          else                            mix_idx   <= mix_idx + 1'b1;
        end
        MIX_OUT: begin
          o_output_sample_left  <= saturate(acc_l);
          o_output_sample_right <= saturate(acc_r);
          mix_state             <= MIX_IDLE;
        end
        default: mix_state <= MIX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_controller_n.sv
// Directed testbench for audio_controller_n (8 channels, 16-bit samples, 8-bit volume).
module tb_audio_controller_n;
  localparam int CH = 8;
  localparam int SW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, req, rw, ready, dma_req, dma_ready, strobe, irq;
  logic [7:0]        addr;
  logic [31:0]       wdata, rdata, dma_addr, rate;
  logic [CH-1:0]     setup_req, setup_append, setup_stereo;
  logic [CH*32-1:0]  setup_addr, ch_dma_addr;
  logic [CH*24-1:0]  setup_count;
  logic [CH-1:0]     ch_busy, ch_dma_req, ch_dma_ready;
  logic [CH*SW-1:0]  smp_l, smp_r;
  logic [SW-1:0]     out_l, out_r;

  int checks = 0;
  int errors = 0;

  audio_controller_n #(.CHANNELS(CH), .SAMPLE_W(SW), .VOL_W(8), .DEFAULT_RATE(32'd17)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_request(req), .i_rw(rw), .i_address(addr),
    .i_wdata(wdata), .o_rdata(rdata), .o_ready(ready),
    .o_dma_request(dma_req), .o_dma_address(dma_addr), .i_dma_ready(dma_ready),
    .o_setup_request(setup_req), .o_setup_address(setup_addr), .o_setup_count(setup_count),
    .o_setup_append(setup_append), .o_setup_stereo(setup_stereo),
    .i_ch_busy(ch_busy), .i_ch_dma_request(ch_dma_req), .i_ch_dma_address(ch_dma_addr),
    .o_ch_dma_ready(ch_dma_ready), .i_ch_sample_left(smp_l), .i_ch_sample_right(smp_r),
    .i_sample_strobe(strobe), .o_output_sample_rate(rate),
    .o_output_sample_left(out_l), .o_output_sample_right(out_r), .o_interrupt(irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
    req = 1'b1; rw = 1'b1; addr = a; wdata = d;
    tick();
    chk("wr_ready", ready, 1);
    req = 1'b0;
    tick();
    chk("wr_release", ready, 0);
  endtask

  task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    req = 1'b1; rw = 1'b0; addr = a;
    tick();
    chk("rd_ready", ready, 1);
    chk(tag, rdata, exp);
    req = 1'b0;
    tick();
  endtask

  task automatic mix_run();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    repeat (9) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; dma_ready = 1'b0;
    ch_busy = '0; ch_dma_req = '0; smp_l = '0; smp_r = '0; strobe = 1'b0;
    for (int c = 0; c < CH; c++) ch_dma_addr[c*32 +: 32] = 32'h1000 + 32'(c) * 32'h100;

    // Reset values
    tick(); tick();
    chk("rst_ready", ready, 0);
    chk("rst_dma_req", dma_req, 0);
    chk("rst_irq", irq, 0);
    chk("rst_out_l", out_l, 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_rate", rate, 17);
    chk("rst_setup_req", setup_req, 0);
    rst_n = 1'b1;
    tick();

    // Register map
    cpu_read(8'hF0, 32'd17, "rate_rd");
    cpu_read(8'h02, 32'h80, "vol0_rst");
    cpu_read(8'hF3, 32'hFF, "mask_rst");
    cpu_read(8'h03, 32'h0, "ch_plus3_rd");
    cpu_read(8'h80, 32'h0, "unmapped_rd");
    cpu_write(8'h80, 32'hDEAD_BEEF);

    // Control write with setup pulse
    req = 1'b1; rw = 1'b1; addr = 8'h01; wdata = 32'h2000_0010;
    tick();
    chk("ctrl_ready", ready, 1);
    chk("setup_pulse", setup_req, 8'h01);
    chk("setup_count0", setup_count[23:0], 24'd16);
    chk("setup_stereo0", setup_stereo[0], 1);
    chk("setup_append0", setup_append[0], 0);
    req = 1'b0;
    tick();
    chk("setup_pulse_end", setup_req, 8'h00);
    cpu_read(8'h01, 32'h2000_0010, "ctrl0_rd");
    cpu_write(8'h15, 32'h1000_0003);
    chk("setup_count5", setup_count[5*24 +: 24], 24'd3);
    chk("setup_append5", setup_append[5], 1);
    cpu_write(8'h00, 32'h1234_5678);
    chk("setup_addr0", setup_addr[31:0], 32'h1234_5678);
    cpu_read(8'h00, 32'h1234_5678, "addr0_rd");
    cpu_write(8'hF0, 32'd99);
    chk("rate_wr", rate, 32'd99);

    // Arbiter: ch1 and ch3 together from pointer 0
    ch_dma_req = 8'b0000_1010;
    tick();
    chk("arb_req_ch1", dma_req, 1);
    chk("arb_addr_ch1", dma_addr, 32'h1100);
    chk("arb_rdy_idle", ch_dma_ready, 8'h00);
    tick(); tick();
    chk("arb_addr_hold", dma_addr, 32'h1100);
    dma_ready = 1'b1;
    #1;
    chk("arb_route_ch1", ch_dma_ready, 8'h02);
    tick();
    dma_ready = 1'b0;
    chk("arb_drop_ch1", dma_req, 0);
    ch_dma_req = 8'b0000_1000;
    tick();
    chk("arb_req_ch3", dma_req, 1);
    chk("arb_addr_ch3", dma_addr, 32'h1300);
    ch_dma_req = 8'h00;
    tick(); tick();
    chk("arb_no_abort", dma_req, 1);
    chk("arb_addr_hold3", dma_addr, 32'h1300);
    dma_ready = 1'b1;
    #1;
    chk("arb_route_ch3", ch_dma_ready, 8'h08);
    tick();
    dma_ready = 1'b0;
    chk("arb_drop_ch3", dma_req, 0);

    // Continuous requests rotate from the pointer (now 4)
    ch_dma_req = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rot_req", dma_req, 1);
      chk("rot_addr", dma_addr, 32'h1000 + 32'((4 + k) % 8) * 32'h100);
      dma_ready = 1'b1;
      tick();
      dma_ready = 1'b0;
    end
    ch_dma_req = 8'h00;
    tick();

    // Mixer: full-scale positive, latency, strobe during ACC ignored
    for (int c = 0; c < CH; c++) begin
      smp_l[c*SW +: SW] = 16'h7FFF;
      smp_r[c*SW +: SW] = 16'h7FFF;
    end
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick(); tick();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    repeat (5) tick();
    chk("mix_early_l", out_l, 16'h0000);
    tick();
    chk("mix_sat_pos_l", out_l, 16'h7FFF);
    chk("mix_sat_pos_r", out_r, 16'h7FFF);

    // Full-scale negative
    for (int c = 0; c < CH; c++) begin
      smp_l[c*SW +: SW] = 16'h8000;
      smp_r[c*SW +: SW] = 16'h8000;
    end
    mix_run();
    chk("mix_sat_neg_l", out_l, 16'h8000);
    chk("mix_sat_neg_r", out_r, 16'h8000);

    // Half volume on ch0 only
    smp_l = '0; smp_r = '0;
    cpu_write(8'h02, 32'h40);
    cpu_read(8'h02, 32'h40, "vol0_rd");
    smp_l[0 +: SW] = 16'h4000;
    mix_run();
    chk("mix_half_l", out_l, 16'h2000);
    chk("mix_half_r", out_r, 16'h0000);

    // Mixed signs, floor behaviour of the arithmetic shift
    smp_r[0 +: SW]  = 16'hFFFF;
    smp_l[SW +: SW] = 16'hF000;
    smp_r[SW +: SW] = 16'h0100;
    mix_run();
    chk("mix_signed_l", out_l, 16'h1000);
    chk("mix_signed_r", out_r, 16'h00FF);

    // Samples are read live during accumulation
    smp_l = '0; smp_r = '0;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    smp_l[7*SW +: SW] = 16'h0123;
    repeat (9) tick();
    chk("mix_live_l", out_l, 16'h0123);
    chk("mix_live_r", out_r, 16'h0000);

    // Interrupt on busy falling edge
    ch_busy = 8'h04;
    tick();
    cpu_read(8'hF1, 32'h04, "busy_rd");
    ch_busy = 8'h00;
    tick();
    chk("irq_lag", irq, 0);
    tick();
    chk("irq_set", irq, 1);
    cpu_read(8'hF2, 32'h04, "pending_rd");
    cpu_write(8'hF3, 32'h00);
    chk("irq_masked", irq, 0);
    cpu_read(8'hF2, 32'h04, "pending_masked");
    cpu_write(8'hF3, 32'hFF);
    chk("irq_unmasked", irq, 1);

    // Set beats same-cycle W1C
    ch_busy = 8'h04;
    tick();
    req = 1'b1; rw = 1'b1; addr = 8'hF2; wdata = 32'h04;
    ch_busy = 8'h00;
    tick();
    req = 1'b0;
    tick();
    cpu_read(8'hF2, 32'h04, "w1c_race");
    cpu_write(8'hF2, 32'h04);
    chk("irq_cleared", irq, 0);
    cpu_read(8'hF2, 32'h00, "pending_cleared");

    // Reset during GRANT and ACC
    ch_busy = 8'h04;
    tick();
    ch_busy = 8'h00;
    tick(); tick();
    chk("pre_rst_irq", irq, 1);
    ch_dma_req = 8'h01;
    tick();
    chk("pre_rst_grant", dma_req, 1);
    chk("pre_rst_addr", dma_addr, 32'h1000);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    rst_n = 1'b0;
    dma_ready = 1'b1;
    tick();
    chk("mid_rst_dma_req", dma_req, 0);
    chk("mid_rst_out_l", out_l, 16'h0000);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_ch_rdy", ch_dma_ready, 8'h00);
    dma_ready = 1'b0;
    ch_dma_req = 8'h00;
    rst_n = 1'b1;
    tick();
    cpu_read(8'hF0, 32'd17, "rate_after_rst");
    cpu_read(8'h02, 32'h80, "vol_after_rst");
    cpu_read(8'hF2, 32'h00, "pending_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
